// File: rtl/mem_access_unit.sv
// mem_access_unit: splits one datapath load/store into 1, 2 or 4 big-endian
// byte transactions on a byte-wide RAM port, extends load results, and
// reports misalignment and bus timeouts alongside MOC.
module mem_access_unit #(
   parameter int unsigned ADDR_W  = 9,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              MOV,
   input  logic              RW,
   input  logic [5:0]        OpC,
   input  logic [ADDR_W-1:0] MAR,
   input  logic [31:0]       DataIn,
   output logic [31:0]       DataOut,
   output logic              MOC,
   output logic              addr_err,
   output logic              bus_err,
   output logic              mem_en,
   output logic              mem_rw,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   input  logic [7:0]        mem_rdata,
   input  logic              mem_ack
);

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;

   localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, CHECK, REQ, DONE} state_t;

   state_t              state_q, state_d;
   logic                rw_q, rw_d;
   logic [5:0]          op_q, op_d;
   logic [ADDR_W-1:0]   mar_q, mar_d;
   logic [31:0]         din_q, din_d;
   logic [31:0]         acc_q, acc_d;
   logic [1:0]          k_q, k_d;
   logic [7:0]          timer_q, timer_d;
   logic                gap_q, gap_d;
   logic [31:0]         dout_q, dout_d;
   logic                aerr_q, aerr_d;
   logic                berr_q, berr_d;

   logic [1:0]          last_idx;
   logic                misaligned;
   logic [31:0]         acc_shift;
   logic [31:0]         ext_data;
   logic [1:0]          wsel;

   // Decode transfer size (index of the last byte) from the latched opcode;
   // unknown opcodes fall back to a full word.
   always_comb begin
      last_idx = 2'd3;
      case (op_q)
         OP_LB, OP_LBU, OP_SB: last_idx = 2'd0;
         OP_LH, OP_LHU, OP_SH: last_idx = 2'd1;
         default:              last_idx = 2'd3;
      endcase
   end

   assign misaligned = ((last_idx == 2'd1) && mar_q[0]) ||
                       ((last_idx == 2'd3) && (mar_q[1:0] != 2'b00));

   assign acc_shift = {acc_q[23:0], mem_rdata};

   // Extend the assembled load value according to the opcode.
   always_comb begin
      ext_data = acc_shift;
      case (op_q)
         OP_LB:   ext_data = {{24{acc_shift[7]}}, acc_shift[7:0]};
         OP_LBU:  ext_data = {24'h000000, acc_shift[7:0]};
         OP_LH:   ext_data = {{16{acc_shift[15]}}, acc_shift[15:0]};
         OP_LHU:  ext_data = {16'h0000, acc_shift[15:0]};
         default: ext_data = acc_shift;
      endcase
   end

   // Big-endian store: byte k carries DataIn byte (N-1-k).
   assign wsel = last_idx - k_q;

   // Select the outgoing store byte.
   always_comb begin
      mem_wdata = din_q[7:0];
      case (wsel)
         2'd0: mem_wdata = din_q[7:0];
         2'd1: mem_wdata = din_q[15:8];
         2'd2: mem_wdata = din_q[23:16];
         2'd3: mem_wdata = din_q[31:24];
         default: mem_wdata = din_q[7:0];
      endcase
   end

   assign mem_en   = (state_q == REQ) && !gap_q;
   assign mem_rw   = rw_q;
   assign mem_addr = mar_q + ADDR_W'(k_q);
   assign MOC      = (state_q == DONE);
   assign DataOut  = dout_q;
   assign addr_err = aerr_q;
   assign bus_err  = berr_q;

   // Next-state and datapath update for the access sequencer.
   always_comb begin
      state_d = state_q;
      rw_d    = rw_q;
      op_d    = op_q;
      mar_d   = mar_q;
      din_d   = din_q;
      acc_d   = acc_q;
      k_d     = k_q;
      timer_d = timer_q;
      gap_d   = gap_q;
      dout_d  = dout_q;
      aerr_d  = aerr_q;
      berr_d  = berr_q;

      case (state_q)
         IDLE: begin
            if (MOV) begin
               rw_d    = RW;
               op_d    = OpC;
               mar_d   = MAR;
               din_d   = DataIn;
               state_d = CHECK;
            end
         end

         CHECK: begin
            if (misaligned) begin
               aerr_d  = 1'b1;
               state_d = DONE;
            end else begin
               acc_d   = '0;
               k_d     = '0;
               timer_d = '0;
               gap_d   = 1'b0;
               state_d = REQ;
            end
         end

         REQ: begin
            if (gap_q) begin
               // mandatory idle cycle between bytes; acks here are ignored
               gap_d = 1'b0;
            end else if (mem_ack) begin
               timer_d = '0;
               if (rw_q) begin
                  acc_d = acc_shift;
               end
               if (k_q == last_idx) begin
                  if (rw_q) begin
                     dout_d = ext_data;
                  end
                  state_d = DONE;
               end else begin
                  k_d   = k_q + 2'd1;
                  gap_d = 1'b1;
               end
            end else if (timer_q == TIMER_LAST) begin
               timer_d = '0;
               berr_d  = 1'b1;
               state_d = DONE;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end

         DONE: begin
            if (!MOV) begin
               aerr_d  = 1'b0;
               berr_d  = 1'b0;
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         rw_q    <= 1'b1;
         op_q    <= '0;
         mar_q   <= '0;
         din_q   <= '0;
         acc_q   <= '0;
         k_q     <= '0;
         timer_q <= '0;
         gap_q   <= 1'b0;
         dout_q  <= '0;
         aerr_q  <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rw_q    <= rw_d;
         op_q    <= op_d;
         mar_q   <= mar_d;
         din_q   <= din_d;
         acc_q   <= acc_d;
         k_q     <= k_d;
         timer_q <= timer_d;
         gap_q   <= gap_d;
         dout_q  <= dout_d;
         aerr_q  <= aerr_d;
         berr_q  <= berr_d;
      end
   end

endmodule
